// File: rtl/fpu_f2i.sv
// IEEE 754 single -> signed 32-bit integer converter with a one-bit-per-cycle alignment shifter.
// Optional round-to-nearest-even when FPU_F2I_ROUND_NEAREST_EN is defined; truncation otherwise.
module fpu_f2i (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] outp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        invalid,
    output logic        inexact
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_next;

`ifdef FPU_F2I_ROUND_NEAREST_EN
    // e == -1 still needs the guard bit, so it goes through the shifter.
    localparam logic [7:0] MIN_SHIFT_EXP = 8'd126;
`else
    localparam logic [7:0] MIN_SHIFT_EXP = 8'd127;
`endif

    logic        a_sign;
    logic [7:0]  a_exp;
    logic [22:0] a_frac;

    logic [31:0] mag;
    logic [4:0]  cnt;
    logic        shift_left;
    logic        sign;
    logic        sticky;
    logic        inv_pend;

    logic [31:0] ld_mag;
    logic [4:0]  ld_cnt;
    logic        ld_left;
    logic        ld_sign;
    logic        ld_sticky;
    logic        ld_inv;

    logic        accept;
    logic        finalize;
    logic        take;

    logic [31:0] mag_rounded;
    logic        fin_inexact;
    logic [31:0] fin_result;

    assign a_sign = A[31];
    assign a_exp  = A[30:23];
    assign a_frac = A[22:0];

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign finalize = (state == SHIFT) && (cnt == 5'd0);
    assign take     = (state == DONE) && out_valid && out_ready;

    // Special cases preload a magnitude/sign pair that finalizes to the saturated or zero result.
    always_comb begin
        ld_mag    = {8'd0, 1'b1, a_frac};
        ld_cnt    = 5'd0;
        ld_left   = 1'b0;
        ld_sign   = a_sign;
        ld_sticky = 1'b0;
        ld_inv    = 1'b0;
        if (a_exp == 8'hFF) begin
            ld_inv = 1'b1;
            if (a_frac != 23'd0) begin
                ld_sign = 1'b0;
                ld_mag  = 32'h7FFF_FFFF;
            end else begin
                ld_mag = a_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else if (a_exp >= 8'd158) begin
            ld_mag = a_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            ld_inv = !(a_sign && (a_exp == 8'd158) && (a_frac == 23'd0));
        end else if (a_exp == 8'd0) begin
            ld_mag    = 32'd0;
            ld_sticky = |a_frac;
        end else if (a_exp < MIN_SHIFT_EXP) begin
            ld_mag    = 32'd0;
            ld_sticky = 1'b1;
        end else if (a_exp >= 8'd150) begin
            ld_left = 1'b1;
            ld_cnt  = 5'(a_exp - 8'd150);
        end else begin
            ld_cnt = 5'(8'd150 - a_exp);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = SHIFT;
            SHIFT:   if (finalize) state_next = DONE;
            DONE:    if (take)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

`ifdef FPU_F2I_ROUND_NEAREST_EN
    logic guard_bit;
    logic round_up;

    // Round half to even: increment on guard when anything below it or the LSB is set.
    assign round_up    = guard_bit && (sticky || mag[0]);
    assign mag_rounded = mag + {31'd0, round_up};
    assign fin_inexact = guard_bit || sticky;

    always_ff @(posedge clk) begin
        if (rst)
            guard_bit <= 1'b0;
        else if (accept)
            guard_bit <= 1'b0;
        else if ((state == SHIFT) && (cnt != 5'd0) && !shift_left)
            guard_bit <= mag[0];
    end
`else
    assign mag_rounded = mag;
    assign fin_inexact = sticky;
`endif

    assign fin_result = sign ? -mag_rounded : mag_rounded;

    always_ff @(posedge clk) begin
        if (rst) begin
            mag        <= 32'd0;
            cnt        <= 5'd0;
            shift_left <= 1'b0;
            sign       <= 1'b0;
            sticky     <= 1'b0;
            inv_pend   <= 1'b0;
            outp       <= 32'd0;
            out_valid  <= 1'b0;
            invalid    <= 1'b0;
            inexact    <= 1'b0;
        end else if (accept) begin
            mag        <= ld_mag;
            cnt        <= ld_cnt;
            shift_left <= ld_left;
            sign       <= ld_sign;
            sticky     <= ld_sticky;
            inv_pend   <= ld_inv;
        end else if (state == SHIFT) begin
            if (cnt != 5'd0) begin
                cnt <= cnt - 5'd1;
                if (shift_left) begin
                    mag <= mag << 1;
                end else begin
                    mag <= mag >> 1;
`ifdef FPU_F2I_ROUND_NEAREST_EN
                    sticky <= sticky | guard_bit;
`else
                    sticky <= sticky | mag[0];
`endif
                end
            end else begin
                outp      <= fin_result;
                inexact   <= fin_inexact;
                invalid   <= inv_pend;
                out_valid <= 1'b1;
            end
        end else if (take) begin
            out_valid <= 1'b0;
            invalid   <= 1'b0;
            inexact   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpu_f2i.sv
// Table-driven bench for fpu_f2i: directed float vectors plus backpressure and mid-shift reset sequences.
// Expected values follow FPU_F2I_ROUND_NEAREST_EN when it is defined.
module tb_fpu_f2i;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] outp;
    logic        out_valid;
    logic        out_ready;
    logic        invalid;
    logic        inexact;

    int pass_count;
    int check_count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    fpu_f2i dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .outp      (outp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Wait for in_ready, present one operand, then count edges until out_valid (-1 on timeout).
    task automatic applyStimulus(input logic [31:0] a, output int lat);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        A        = a;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic takeResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        pass_count  = 0;
        check_count = 0;

`ifdef FPU_F2I_ROUND_NEAREST_EN
        vecs[8]  = '{32'h3FC0_0000, 32'h0000_0002, 1'b0, 1'b1, 24};
        vecs[10] = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 25};
        vecs[11] = '{32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 24};
        vecs[14] = '{32'h3F40_0000, 32'h0000_0001, 1'b0, 1'b1, 25};
`else
        vecs[8]  = '{32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 24};
        vecs[10] = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1};
        vecs[11] = '{32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 24};
        vecs[14] = '{32'h3F40_0000, 32'h0000_0000, 1'b0, 1'b1, 1};
`endif
        vecs[0]  = '{32'h4049_0FDB, 32'h0000_0003, 1'b0, 1'b1, 23};
        vecs[1]  = '{32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 18};
        vecs[2]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 8};
        vecs[3]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        vecs[4]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1};
        vecs[5]  = '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        vecs[6]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1};
        vecs[7]  = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1};
        vecs[9]  = '{32'h4020_0000, 32'h0000_0002, 1'b0, 1'b1, 23};
        vecs[12] = '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 1};
        vecs[13] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[15] = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        vecs[16] = '{32'h3E80_0000, 32'h0000_0000, 1'b0, 1'b1, 1};
        vecs[17] = '{32'hC120_0001, 32'hFFFF_FFF6, 1'b0, 1'b1, 21};

        rst       = 1'b1;
        A         = 32'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outp", outp, 32'd0);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_invalid", {31'd0, invalid}, 32'd0);
        checkOutput("reset_inexact", {31'd0, inexact}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].a, lat);
            checkOutput($sformatf("v%0d_outp", i), outp, vecs[i].res);
            checkOutput($sformatf("v%0d_invalid", i), {31'd0, invalid}, {31'd0, vecs[i].inv});
            checkOutput($sformatf("v%0d_inexact", i), {31'd0, inexact}, {31'd0, vecs[i].inx});
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            takeResult();
            checkOutput($sformatf("v%0d_taken_valid", i), {31'd0, out_valid}, 32'd0);
            checkOutput($sformatf("v%0d_taken_flags", i), {30'd0, invalid, inexact}, 32'd0);
            checkOutput($sformatf("v%0d_taken_ready", i), {31'd0, in_ready}, 32'd1);
        end

        // Backpressure: result must hold and a stray operand must be ignored.
        applyStimulus(32'h4049_0FDB, lat);
        checkOutput("bp_latency", 32'(lat), 32'd23);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            A        = 32'h4120_0000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp%0d_outp", c), outp, 32'd3);
            checkOutput($sformatf("bp%0d_flags", c), {30'd0, invalid, inexact}, 32'd1);
            checkOutput($sformatf("bp%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready_before", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        checkOutput("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_release_in_ready_after", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_release_inexact", {31'd0, inexact}, 32'd0);

        // Reset in the middle of SHIFT drops the pending conversion.
        @(negedge clk);
        A        = 32'h3F80_0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_in_ready_during", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_mid_outp", outp, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_idle", {31'd0, in_ready}, 32'd1);
        begin
            logic seen_valid;
            seen_valid = 1'b0;
            repeat (25) begin
                @(posedge clk);
                #1;
                if (out_valid) seen_valid = 1'b1;
            end
            checkOutput("rst_mid_no_result", {31'd0, seen_valid}, 32'd0);
        end
        applyStimulus(32'h4120_0000, lat);
        checkOutput("after_rst_outp", outp, 32'd10);
        checkOutput("after_rst_flags", {30'd0, invalid, inexact}, 32'd0);
        checkOutput("after_rst_latency", 32'(lat), 32'd21);
        takeResult();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
